// File: rtl/cache_line_fill.sv
// cache_line_fill
// Refill engine for a direct-mapped cache. On a miss it requests one line
// from the SPI flash reader. It packs the returned bytes little-endian into
// 32-bit words and writes each word into the line's slot of the data RAM.
// The RAM port is shared, so each word waits for an arbiter grant.

module cache_line_fill #(
    parameter int LINE_WORDS = 8,
    parameter int RAM_AW     = 10,
    parameter int FLASH_AW   = 24
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                fill_req_i,
    input  logic [FLASH_AW-1:0] fill_addr_i,
    output logic                fill_ready_o,
    output logic                fill_done_o,
    input  logic                abort_i,

    output logic                spi_req_o,
    output logic [FLASH_AW-1:0] spi_addr_o,
    output logic [15:0]         spi_len_o,
    input  logic                spi_gnt_i,
    input  logic [7:0]          spi_data_i,
    input  logic                spi_valid_i,
    output logic                spi_ready_o,
    output logic                spi_abort_o,

    output logic                ram_en_o,
    output logic [RAM_AW-1:0]   ram_addr_o,
    output logic [31:0]         ram_wdata_o,
    output logic [3:0]          ram_we_o,
    input  logic                ram_gnt_i
);

    localparam int OFF_W = $clog2(LINE_WORDS * 4);
    localparam int WC_W  = $clog2(LINE_WORDS);
    localparam int IDX_W = RAM_AW - WC_W;

    localparam logic [WC_W-1:0]     LAST_WORD = WC_W'(LINE_WORDS - 1);
    localparam logic [15:0]         LINE_LEN  = 16'(LINE_WORDS * 4);
    localparam logic [FLASH_AW-1:0] LINE_MASK = {{(FLASH_AW-OFF_W){1'b1}}, {OFF_W{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_STREAM = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Control state
    state_t              state_q,     state_d;
    logic [FLASH_AW-1:0] line_addr_q, line_addr_d;
    logic [IDX_W-1:0]    line_idx_q,  line_idx_d;
    logic [WC_W-1:0]     word_cnt_q,  word_cnt_d;
    logic [1:0]          byte_cnt_q,  byte_cnt_d;
    logic [31:0]         word_buf_q,  word_buf_d;

    // Registered outputs
    logic                fill_ready_q, fill_ready_d;
    logic                fill_done_q,  fill_done_d;
    logic                spi_req_q,    spi_req_d;
    logic [FLASH_AW-1:0] spi_addr_q,   spi_addr_d;
    logic                spi_ready_q,  spi_ready_d;
    logic                spi_abort_q,  spi_abort_d;
    logic                ram_en_q,     ram_en_d;
    logic [RAM_AW-1:0]   ram_addr_q,   ram_addr_d;
    logic [31:0]         ram_wdata_q,  ram_wdata_d;
    logic [3:0]          ram_we_q,     ram_we_d;

    logic                beat_s;

    assign beat_s = spi_valid_i & spi_ready_q;

    // Next-state, datapath and next-output computation
    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        line_idx_d  = line_idx_q;
        word_cnt_d  = word_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        word_buf_d  = word_buf_q;
        spi_abort_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fill_req_i) begin
                    line_addr_d = fill_addr_i & LINE_MASK;
                    line_idx_d  = fill_addr_i[OFF_W +: IDX_W];
                    state_d     = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                // The reader has not started a transfer yet, so there is
                // nothing to tell it to drop.
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (spi_gnt_i) begin
                    state_d = ST_STREAM;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_STREAM: begin
                if (abort_i) begin
                    spi_abort_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (beat_s) begin
                    word_buf_d[{byte_cnt_q, 3'b000} +: 8] = spi_data_i;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_WRITE: begin
                if (abort_i) begin
                    spi_abort_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (ram_gnt_i) begin
                    if (word_cnt_q == LAST_WORD) begin
                        state_d = ST_DONE;
                    end else begin
                        word_cnt_d = word_cnt_q + WC_W'(1);
                        state_d    = ST_STREAM;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Counters restart from zero for every new line; a partial word
        // left behind by an abort is simply discarded here.
        if (state_d == ST_IDLE) begin
            word_cnt_d = {WC_W{1'b0}};
            byte_cnt_d = 2'd0;
            word_buf_d = 32'd0;
        end else begin
            word_cnt_d = word_cnt_d;
        end

        // Outputs are a function of the state being entered so that they
        // come straight out of flops.
        fill_ready_d = 1'b0;
        fill_done_d  = 1'b0;
        spi_req_d    = 1'b0;
        spi_addr_d   = {FLASH_AW{1'b0}};
        spi_ready_d  = 1'b0;
        ram_en_d     = 1'b0;
        ram_addr_d   = {RAM_AW{1'b0}};
        ram_wdata_d  = 32'd0;
        ram_we_d     = 4'h0;
        case (state_d)
            ST_IDLE: begin
                fill_ready_d = 1'b1;
            end
            ST_REQ: begin
                spi_req_d  = 1'b1;
                spi_addr_d = line_addr_d;
            end
            ST_STREAM: begin
                spi_ready_d = 1'b1;
            end
            ST_WRITE: begin
                ram_en_d    = 1'b1;
                ram_we_d    = 4'hF;
                ram_addr_d  = {line_idx_d, word_cnt_d};
                ram_wdata_d = word_buf_d;
            end
            ST_DONE: begin
                fill_done_d = 1'b1;
            end
            default: begin
                fill_ready_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            line_addr_q  <= {FLASH_AW{1'b0}};
            line_idx_q   <= {IDX_W{1'b0}};
            word_cnt_q   <= {WC_W{1'b0}};
            byte_cnt_q   <= 2'd0;
            word_buf_q   <= 32'd0;
            fill_ready_q <= 1'b1;
            fill_done_q  <= 1'b0;
            spi_req_q    <= 1'b0;
            spi_addr_q   <= {FLASH_AW{1'b0}};
            spi_ready_q  <= 1'b0;
            spi_abort_q  <= 1'b0;
            ram_en_q     <= 1'b0;
            ram_addr_q   <= {RAM_AW{1'b0}};
            ram_wdata_q  <= 32'd0;
            ram_we_q     <= 4'h0;
        end else begin
            state_q      <= state_d;
            line_addr_q  <= line_addr_d;
            line_idx_q   <= line_idx_d;
            word_cnt_q   <= word_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            word_buf_q   <= word_buf_d;
            fill_ready_q <= fill_ready_d;
            fill_done_q  <= fill_done_d;
            spi_req_q    <= spi_req_d;
            spi_addr_q   <= spi_addr_d;
            spi_ready_q  <= spi_ready_d;
            spi_abort_q  <= spi_abort_d;
            ram_en_q     <= ram_en_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_we_q     <= ram_we_d;
        end
    end

    assign fill_ready_o = fill_ready_q;
    assign fill_done_o  = fill_done_q;
    assign spi_req_o    = spi_req_q;
    assign spi_addr_o   = spi_addr_q;
    assign spi_len_o    = LINE_LEN;
    assign spi_ready_o  = spi_ready_q;
    assign spi_abort_o  = spi_abort_q;
    assign ram_addr_o   = ram_addr_q;
    assign ram_wdata_o  = ram_wdata_q;

    // An abort that coincides with a grant must not commit the word, so the
    // enables are masked combinationally by abort_i in that cycle.
    assign ram_en_o = ram_en_q & ~abort_i;
    assign ram_we_o = ram_we_q & {4{~abort_i}};

endmodule
